ex_muldiv_unit: RTL
===================

# ex_muldiv_unit

Iterative multiply/divide unit in the EX stage. Consumes operands and control from the ID/EX pipeline register and, while it works, holds that register and the upstream stages with a stall signal. Produces the architectural HI/LO pair for MULT/MULTU/DIV/DIVU and services MTHI/MTLO writes. It is the downstream reader of the ID/EX register, with the stall handshake running back toward it.

## Interface
- No parameters. Width is fixed at 32 bits.
- Clk  in  1  sole clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high.
- Start  in  1  begin an operation. Sampled only in IDLE.
- Op  in  2  operation: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- A  in  32  rs operand (EX_ReadData1). Multiplicand or dividend.
- B  in  32  rt operand (EX_ReadData2). Multiplier or divisor.
- WriteHI  in  1  MTHI strobe.
- WriteLO  in  1  MTLO strobe.
- WriteData  in  32  MTHI/MTLO data.
- Stall  out  1  combinational; equals Busy. Freezes ID/EX and earlier stages.
- Busy  out  1  registered; operation in progress.
- Done  out  1  registered; one-cycle pulse when HI/LO are updated.
- HI  out  32  registered; high product or remainder.
- LO  out  32  registered; low product or quotient.

## Operation
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE + Start with Op[1]=0 → MUL; IDLE + Start with Op[1]=1 → DIV.
  - MUL/DIV run 32 iterations, counted 0..31. At count 31 the FSM moves to FIX.
  - FIX → IDLE unconditionally.
- Signed ops (MULT, DIV):
  - Operands are converted to magnitudes at Start.
  - The result sign is latched at Start: product sign = A[31]^B[31]; quotient sign = A[31]^B[31]; remainder sign = A[31].
  - Negation is applied in FIX.
- MUL: shift-add, one multiplier bit per cycle, 64-bit accumulator.
- DIV: restoring division, one quotient bit per cycle, 33-bit partial remainder.
- Divide by zero, both DIV and DIVU: LO=32'hFFFF_FFFF, HI=A unchanged.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF: LO=32'h8000_0000, HI=0. No trap. This falls out naturally from magnitude arithmetic.
- FIX writes HI/LO and asserts Done on the following cycle.
- MTHI/MTLO:
  - Accepted only in IDLE with Start low. The write takes effect on the next edge.
  - Ignored when Busy is high or when Start is high. Start wins.
  - WriteHI and WriteLO may both be high in the same cycle; both registers take WriteData.
- Start while Busy is ignored. Op, A and B are captured only at the accepted Start.

## Timing
- Reset values: state=IDLE, Busy=0, Done=0, HI=0, LO=0, counter=0, internal accumulators=0.
- Start accepted at edge E0. Busy=1 after E0 through edge E33 (MUL/DIV for 32 cycles plus FIX).
- After edge E34: HI/LO hold the final result, Done=1 for exactly one cycle, Busy=0.
- Latency from accepted Start to valid HI/LO is 34 cycles. The next Start may be accepted in the same cycle Done is high.
- Stall follows Busy with no added delay. The pipeline sees the stall from the cycle after E0.
- Reset mid-operation: next edge returns to IDLE with HI=LO=0 and Done=0. The partial result is discarded and Done is never pulsed.
- HI/LO are stable and hold their old values throughout MUL/DIV. They change only in FIX, on an MTHI/MTLO write, or on reset.

## Structure
- Shared package muldiv_pkg holds:
  - Op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - FSM state encodings.
  - ITER_COUNT=32.
  - DIV0_QUOT=32'hFFFF_FFFF.
- One sub-module, muldiv_datapath:
  - Contains the accumulator/remainder registers, the shift-add and subtract-restore step, and the sign fixup.
  - Controlled by the FSM in ex_muldiv_unit through load, step and fix strobes.

## Test plan
- MULT A=7, B=32'hFFFF_FFFD (−3) → after 34 cycles, Done=1, HI=32'hFFFF_FFFF, LO=32'hFFFF_FFEB; Stall high for exactly 34 cycles.
- MULTU A=B=32'hFFFF_FFFF → HI=32'hFFFF_FFFE, LO=32'h0000_0001.
- DIV A=32'hFFFF_FFF9 (−7), B=2 → LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF.
- DIVU A=100, B=0 → LO=32'hFFFF_FFFF, HI=32'h0000_0064.
- DIV A=32'h8000_0000, B=32'hFFFF_FFFF → LO=32'h8000_0000, HI=0.
- Three checks in one run:
  - Start a MULT, pulse Start and WriteHI during Busy → both ignored.
  - Assert Reset at cycle 10 of a second op → Busy=0, HI=LO=0, no Done.
  - Then MTLO 32'h1234_5678 in IDLE → LO=32'h1234_5678 on the next cycle.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the EX-stage multiply/divide unit.
// Op encodings, FSM states and the datapath control bundle.
package muldiv_pkg;

    localparam int          ITER_COUNT = 32;
    localparam logic [31:0] DIV0_QUOT  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } muldivOp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } muldivState_t;

    typedef struct packed {
        logic load;
        logic step;
        logic fix;
    } dpCtrl_t;

    function automatic logic [31:0] magnitude(
        input logic [31:0] v,
        input logic        isSigned
    );
        return (isSigned && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiplier / restoring divider with sign fixup.
// Driven by load, step and fix strobes from the unit FSM.
module muldiv_datapath
    import muldiv_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  dpCtrl_t     ctrl,
    input  muldivOp_t   op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] resHi,
    output logic [31:0] resLo
);

    logic [63:0] acc;
    logic [31:0] opB;
    logic [31:0] rem;
    logic        isDivR;
    logic        negLo;
    logic        negHi;
    logic        div0;

    logic        signedOp;
    logic        isDivOp;
    logic [32:0] mulSum;
    logic [32:0] divShift;
    logic [32:0] divDiff;
    logic [63:0] prodNeg;

    assign signedOp = (op == OP_MULT) || (op == OP_DIV);
    assign isDivOp  = (op == OP_DIV) || (op == OP_DIVU);

    assign mulSum   = {1'b0, acc[63:32]}
                    + (acc[0] ? {1'b0, opB} : 33'd0);
    assign divShift = {rem, acc[31]};
    assign divDiff  = divShift - {1'b0, opB};
    assign prodNeg  = ~acc + 64'd1;

    // Load magnitudes and result signs, iterate, then apply the signs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            acc    <= '0;
            opB    <= '0;
            rem    <= '0;
            isDivR <= 1'b0;
            negLo  <= 1'b0;
            negHi  <= 1'b0;
            div0   <= 1'b0;
            resHi  <= '0;
            resLo  <= '0;
        end else if (ctrl.load) begin
            acc    <= {32'd0, magnitude(a, signedOp)};
            opB    <= magnitude(b, signedOp);
            rem    <= '0;
            isDivR <= isDivOp;
            negLo  <= signedOp & (a[31] ^ b[31]);
            negHi  <= signedOp & (isDivOp ? a[31]
                                          : (a[31] ^ b[31]));
            div0   <= (b == 32'd0);
        end else if (ctrl.step) begin
            if (isDivR) begin
                if (!divDiff[32]) begin
                    rem       <= divDiff[31:0];
                    acc[31:0] <= {acc[30:0], 1'b1};
                end else begin
                    rem       <= divShift[31:0];
                    acc[31:0] <= {acc[30:0], 1'b0};
                end
            end else begin
                acc <= {mulSum, acc[31:1]};
            end
        end else if (ctrl.fix) begin
            if (isDivR) begin
                resHi <= negHi ? (~rem + 32'd1) : rem;
                if (div0)
                    resLo <= DIV0_QUOT;
                else if (negLo)
                    resLo <= ~acc[31:0] + 32'd1;
                else
                    resLo <= acc[31:0];
            end else begin
                {resHi, resLo} <= negLo ? prodNeg : acc;
            end
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Stalls the upstream pipeline while an operation runs.
module ex_muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        WriteHI,
    input  logic        WriteLO,
    input  logic [31:0] WriteData,
    output logic        Stall,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    muldivState_t state;
    muldivState_t nextState;
    dpCtrl_t      ctrl;
    logic [4:0]   cnt;
    logic         wbPend;
    logic         accept;
    logic         mtOk;
    logic [31:0]  resHi;
    logic [31:0]  resLo;

    assign accept = (state == IDLE) && Start && !Busy;
    assign mtOk   = (state == IDLE) && !Start && !Busy;
    assign Stall  = Busy;

    muldiv_datapath uDp (
        .Clk   (Clk),
        .Reset (Reset),
        .ctrl  (ctrl),
        .op    (muldivOp_t'(Op)),
        .a     (A),
        .b     (B),
        .resHi (resHi),
        .resLo (resLo)
    );

    // Next state and datapath strobes.
    always_comb begin
        nextState = state;
        ctrl      = '0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    ctrl.load = 1'b1;
                    nextState = Op[1] ? DIV : MUL;
                end
            end
            MUL, DIV: begin
                ctrl.step = 1'b1;
                if (cnt == 5'(ITER_COUNT - 1))
                    nextState = FIX;
            end
            FIX: begin
                ctrl.fix  = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // State register and iteration counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nextState;
            cnt   <= ctrl.step ? cnt + 5'd1 : 5'd0;
        end
    end

    // Busy/Done handshake and the architectural HI/LO pair.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Busy   <= 1'b0;
            Done   <= 1'b0;
            wbPend <= 1'b0;
            HI     <= '0;
            LO     <= '0;
        end else begin
            wbPend <= ctrl.fix;
            Done   <= wbPend;
            if (accept)
                Busy <= 1'b1;
            else if (wbPend)
                Busy <= 1'b0;
            if (wbPend) begin
                HI <= resHi;
                LO <= resLo;
            end else if (mtOk) begin
                if (WriteHI)
                    HI <= WriteData;
                if (WriteLO)
                    LO <= WriteData;
            end
        end
    end

endmodule
